// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - request and status bundle for the program sequencer
interface program_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic              en;
    logic              jump;
    logic              call;
    logic              ret;
    logic              skip;
    logic              clear_err;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] address;
    logic [DW-1:0]     depth;
    logic              overflow;
    logic              underflow;

    modport master (
        output en, jump, call, ret, skip, clear_err, target,
        input  address, depth, overflow, underflow
    );

    modport slave (
        input  en, jump, call, ret, skip, clear_err, target,
        output address, depth, overflow, underflow
    );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter with return stack, skip and sticky stack errors
module program_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    program_sequencer_if.slave   bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DW-1:0]     depth_q, depth_n;
    logic              ovf_q, unf_q;
    logic              ovf_set, unf_set;
    logic              push;
    logic [ADDR_W-1:0] stack [DEPTH];

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_skip;
    logic [DW-1:0]     depth_dec;
    logic [IW-1:0]     push_idx;
    logic [IW-1:0]     pop_idx;
    logic              stack_full;
    logic              stack_empty;

    assign addr_inc    = addr_q + ADDR_W'(1);
    assign addr_skip   = addr_q + ADDR_W'(2);
    assign depth_dec   = depth_q - DW'(1);
    assign push_idx    = depth_q[IW-1:0];
    assign pop_idx     = depth_dec[IW-1:0];
    assign stack_full  = (depth_q == DW'(DEPTH));
    assign stack_empty = (depth_q == '0);

    always_comb begin
        addr_n  = addr_q;
        depth_n = depth_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                // Empty-stack return degrades to a plain increment so execution keeps moving.
                if (!stack_empty) begin
                    addr_n  = stack[pop_idx];
                    depth_n = depth_dec;
                end else begin
                    addr_n  = addr_inc;
                    unf_set = 1'b1;
                end
            end else if (bus.call) begin
                addr_n = bus.target;
                if (!stack_full) begin
                    push    = 1'b1;
                    depth_n = depth_q + DW'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (bus.jump) begin
                addr_n = bus.target;
            end else if (bus.skip) begin
                addr_n = addr_skip;
            end else begin
                addr_n = addr_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_n;
            depth_q <= depth_n;
            ovf_q   <= ovf_set | (ovf_q & ~bus.clear_err);
            unf_q   <= unf_set | (unf_q & ~bus.clear_err);
        end
    end

    // Stack storage is left unreset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= addr_inc;
        end
    end

    assign bus.address   = addr_q;
    assign bus.depth     = depth_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed scoreboard bench for program_sequencer
module tb_program_sequencer;
    logic clk;
    logic reset;

    program_sequencer_if #(.ADDR_W(8), .DEPTH(4)) bus ();

    program_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    function automatic logic [12:0] pack(input logic [7:0] a, input logic [2:0] d,
                                         input logic o, input logic u);
        return {a, d, o, u};
    endfunction

    task automatic expect_state(input string tag, input logic [7:0] a, input logic [2:0] d,
                                input logic o, input logic u);
        exp_t e;
        e.tag = tag;
        e.val = pack(a, d, o, u);
        exp_q.push_back(e);
    endtask

    task automatic check_front();
        exp_t        e;
        logic [12:0] obs;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = exp_q.pop_front();
            obs = pack(bus.address, bus.depth, bus.overflow, bus.underflow);
            assert (obs === e.val)
            else begin
                fails++;
                $error("FAIL %s observed addr=%h depth=%0d ovf=%b unf=%b expected addr=%h depth=%0d ovf=%b unf=%b",
                       e.tag, obs[12:5], obs[4:2], obs[1], obs[0],
                       e.val[12:5], e.val[4:2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic step(input string tag, input logic e, input logic j, input logic c,
                        input logic r, input logic s, input logic ce, input logic [7:0] tgt,
                        input logic [7:0] ea, input logic [2:0] ed, input logic eo, input logic eu);
        bus.en        = e;
        bus.jump      = j;
        bus.call      = c;
        bus.ret       = r;
        bus.skip      = s;
        bus.clear_err = ce;
        bus.target    = tgt;
        expect_state(tag, ea, ed, eo, eu);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b0;
        bus.en        = 1'b0;
        bus.jump      = 1'b0;
        bus.call      = 1'b0;
        bus.ret       = 1'b0;
        bus.skip      = 1'b0;
        bus.clear_err = 1'b0;
        bus.target    = 8'h00;

        #12;
        expect_state("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        check_front();
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_state("reset_release", 8'h00, 3'd0, 1'b0, 1'b0);
        check_front();
        @(posedge clk);
        #1;

        for (int i = 1; i <= 256; i++) begin
            step("increment_run", 1, 0, 0, 0, 0, 0, 8'h00, 8'(i % 256), 3'd0, 0, 0);
        end

        step("jump_10",      1, 1, 0, 0, 0, 0, 8'h10, 8'h10, 3'd0, 0, 0);
        step("call_40",      1, 0, 1, 0, 0, 0, 8'h40, 8'h40, 3'd1, 0, 0);
        step("inc_41",       1, 0, 0, 0, 0, 0, 8'h00, 8'h41, 3'd1, 0, 0);
        step("inc_42",       1, 0, 0, 0, 0, 0, 8'h00, 8'h42, 3'd1, 0, 0);
        step("inc_43",       1, 0, 0, 0, 0, 0, 8'h00, 8'h43, 3'd1, 0, 0);
        step("ret_11",       1, 0, 0, 1, 0, 0, 8'h00, 8'h11, 3'd0, 0, 0);

        step("jump_05",      1, 1, 0, 0, 0, 0, 8'h05, 8'h05, 3'd0, 0, 0);
        step("ret_empty",    1, 0, 0, 1, 0, 0, 8'h00, 8'h06, 3'd0, 0, 1);
        step("hold_unf",     0, 0, 0, 0, 0, 0, 8'h00, 8'h06, 3'd0, 0, 1);
        step("clear_unf",    0, 0, 0, 0, 0, 1, 8'h00, 8'h06, 3'd0, 0, 0);
        step("set_wins",     1, 0, 0, 1, 0, 1, 8'h00, 8'h07, 3'd0, 0, 1);
        step("clear_unf2",   0, 0, 0, 0, 0, 1, 8'h00, 8'h07, 3'd0, 0, 0);

        step("jump_00",      1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        step("call_1",       1, 0, 1, 0, 0, 0, 8'h80, 8'h80, 3'd1, 0, 0);
        step("call_2",       1, 0, 1, 0, 0, 0, 8'h80, 8'h80, 3'd2, 0, 0);
        step("call_3",       1, 0, 1, 0, 0, 0, 8'h80, 8'h80, 3'd3, 0, 0);
        step("call_4",       1, 0, 1, 0, 0, 0, 8'h80, 8'h80, 3'd4, 0, 0);
        step("call_5_ovf",   1, 0, 1, 0, 0, 0, 8'h80, 8'h80, 3'd4, 1, 0);
        step("en0_call",     0, 0, 1, 0, 0, 0, 8'h33, 8'h80, 3'd4, 1, 0);
        step("ret_a",        1, 0, 0, 1, 0, 0, 8'h00, 8'h81, 3'd3, 1, 0);
        step("ret_b",        1, 0, 0, 1, 0, 0, 8'h00, 8'h81, 3'd2, 1, 0);
        step("ret_c",        1, 0, 0, 1, 0, 0, 8'h00, 8'h81, 3'd1, 1, 0);
        step("ret_d",        1, 0, 0, 1, 0, 0, 8'h00, 8'h01, 3'd0, 1, 0);
        step("clear_ovf",    0, 0, 0, 0, 0, 1, 8'h00, 8'h01, 3'd0, 0, 0);

        step("jump_ff",      1, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 3'd0, 0, 0);
        step("skip_wrap_01", 1, 0, 0, 0, 1, 0, 8'h00, 8'h01, 3'd0, 0, 0);
        step("jump_fe",      1, 1, 0, 0, 0, 0, 8'hFE, 8'hFE, 3'd0, 0, 0);
        step("skip_wrap_00", 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        step("jump_over_skip", 1, 1, 0, 0, 1, 0, 8'h20, 8'h20, 3'd0, 0, 0);
        step("call_30",      1, 0, 1, 0, 0, 0, 8'h30, 8'h30, 3'd1, 0, 0);
        step("ret_over_call", 1, 0, 1, 1, 0, 0, 8'h50, 8'h21, 3'd0, 0, 0);
        step("no_push_check", 1, 0, 0, 1, 0, 0, 8'h00, 8'h22, 3'd0, 0, 1);
        step("clear_unf3",   0, 0, 0, 0, 0, 1, 8'h00, 8'h22, 3'd0, 0, 0);

        step("call_60",      1, 0, 1, 0, 0, 0, 8'h60, 8'h60, 3'd1, 0, 0);
        step("call_70",      1, 0, 1, 0, 0, 0, 8'h70, 8'h70, 3'd2, 0, 0);
        bus.en   = 1'b0;
        bus.call = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        expect_state("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        check_front();
        @(negedge clk);
        reset = 1'b1;
        #1;
        step("en0_after_rst", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        step("stack_flushed", 1, 0, 0, 1, 0, 0, 8'h00, 8'h01, 3'd0, 0, 1);

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the program address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of return-stack entries (DEPTH >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; when 0 all state holds.
REQ-006 The block SHALL have port jump, input, 1 bit: load target as the next address.
REQ-007 The block SHALL have port call, input, 1 bit: push the return address and load target.
REQ-008 The block SHALL have port ret, input, 1 bit: pop the stack top into the address.
REQ-009 The block SHALL have port skip, input, 1 bit: advance by 2 instead of 1 (conditional skip, already qualified by the caller).
REQ-010 The block SHALL have port clear_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port target, input, ADDR_W bits: destination address for jump/call.
REQ-012 The block SHALL have port address, output, ADDR_W bits: current program address, driven directly from the register.
REQ-013 The block SHALL have port depth, output, $clog2(DEPTH+1) bits: number of valid stack entries.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag, call attempted while the stack is full.
REQ-015 The block SHALL have port underflow, output, 1 bit: sticky flag, ret attempted while the stack is empty.

Function
REQ-016 The block SHALL take one action per enabled cycle, priority ret > call > jump > skip > increment.
REQ-017 With en=0 the block SHALL hold address, the stack and depth; clear_err SHALL still act.
REQ-018 Increment SHALL be address+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-019 Skip SHALL be address+2 modulo 2^ADDR_W (all-ones wraps to 1; all-ones-minus-1 wraps to 0).
REQ-020 Jump SHALL load target on the next edge; the stack is unchanged.
REQ-021 Call with depth<DEPTH SHALL push (address+1) mod 2^ADDR_W, increment depth, and load target, all on the same edge.
REQ-022 Call with depth=DEPTH SHALL load target, leave the stack and depth unchanged, and set overflow.
REQ-023 Ret with depth>0 SHALL load the top entry into address and decrement depth (LIFO order).
REQ-024 Ret with depth=0 SHALL perform a normal increment and set underflow; depth stays 0.
REQ-025 Lower-priority requests asserted together with a higher one SHALL be ignored for that cycle, with no side effects.
REQ-026 Overflow and underflow SHALL stay set until clear_err=1 or reset; if a set condition and clear_err occur in the same cycle, set SHALL win.
REQ-027 Every output change SHALL appear one clock after the enabled request; there is no combinational path from inputs to outputs.
REQ-028 Stack entries above depth SHALL not be observable; their contents are don't-care.

Reset
REQ-029 While reset=0 the block SHALL force address=0, depth=0, overflow=0, underflow=0, independent of clk.
REQ-030 Reset asserted mid-sequence SHALL discard all stack contents; the first enabled edge after release SHALL act from address 0.
REQ-031 Stack storage SHALL not require a reset value.

Verification
REQ-032 Bench SHALL cover: reset release, en=1 for 257 cycles at ADDR_W=8 -> address sequence 0..255, 0; depth=0 throughout.
REQ-033 Bench SHALL cover: at address 0x10, call target 0x40, then 3 increments, then ret -> address 0x40, 0x41, 0x42, 0x43, then 0x11; depth 1 then 0.
REQ-034 Bench SHALL cover: DEPTH=4, five consecutive calls to 0x80 from 0x00 -> depth=4, overflow=1 after the fifth call, address=0x80; four rets return 0x81, 0x81, 0x81, 0x01.
REQ-035 Bench SHALL cover: ret at depth=0 from address 0x05 -> address=0x06, underflow=1; clear_err pulse -> underflow=0.
REQ-036 Bench SHALL cover: at address 0xFF, skip -> 0x01; jump+skip with target 0x20 -> 0x20; ret+call at depth 1 -> pop wins, no push.
REQ-037 Bench SHALL cover: reset asserted asynchronously between edges with depth=2 -> address=0 and depth=0 immediately; en=0 after release -> address holds 0.
